// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared states, default VGA timing and address width for the OV7670 stream generator
package ov7670_pkg;
    typedef enum logic [2:0] {IDLE, SYNC, BACK, ACTIVE, FRONT} state_t;

    localparam int H_ACTIVE_DEF    = 640;
    localparam int H_BLANK_DEF     = 144;
    localparam int V_ACTIVE_DEF    = 480;
    localparam int VSYNC_LINES_DEF = 3;
    localparam int V_BACK_DEF      = 17;
    localparam int V_FRONT_DEF     = 10;
    localparam logic [7:0] FILL_BYTE_DEF = 8'h00;
    localparam int ADDR_W          = 19;
endpackage

// File: rtl/ov7670_timing_gen.sv
// rtl/ov7670_timing_gen.sv - col/line counters and frame FSM; raw flags; OV7670_STREAM_TESTPAT_EN adds pat
module ov7670_timing_gen
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_BLANK     = H_BLANK_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int VSYNC_LINES = VSYNC_LINES_DEF,
    parameter int V_BACK      = V_BACK_DEF,
    parameter int V_FRONT     = V_FRONT_DEF
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       en,
    output logic       raw_vsync,
    output logic       raw_href,
    output logic       raw_rd,
    output logic       raw_fill,
    output logic       frame_start,
    output logic       frame_end
`ifdef OV7670_STREAM_TESTPAT_EN
    ,
    output logic [7:0] pat
`endif
);
    localparam int L        = 2 * (H_ACTIVE + H_BLANK);
    localparam int F        = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int CW       = $clog2(L);
    localparam int LW       = $clog2(F);
    localparam int BACK_END = VSYNC_LINES + V_BACK;
    localparam int ACT_END  = BACK_END + V_ACTIVE;

    state_t          state, next_state;
    logic [CW-1:0]   col;
    logic [LW-1:0]   ln;
    logic            line_end;

    assign line_end    = (col == CW'(L - 1));
    assign frame_end   = (state == FRONT) && (ln == LW'(F - 1)) && line_end;
    assign frame_start = (state == SYNC) && (ln == '0) && (col == '0);
    assign raw_vsync   = (state == SYNC);
    assign raw_href    = (state == ACTIVE) && (col < CW'(2 * H_ACTIVE));
    assign raw_rd      = raw_href && !col[0];
    assign raw_fill    = raw_href && col[0];

`ifdef OV7670_STREAM_TESTPAT_EN
    assign pat = 8'(col >> 1) ^ 8'(ln - LW'(BACK_END));
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (en) next_state = SYNC;
            SYNC:    if (line_end && ln == LW'(VSYNC_LINES - 1)) next_state = BACK;
            BACK:    if (line_end && ln == LW'(BACK_END - 1)) next_state = ACTIVE;
            ACTIVE:  if (line_end && ln == LW'(ACT_END - 1)) next_state = FRONT;
            FRONT:   if (frame_end) next_state = en ? SYNC : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= '0;
            ln    <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                col <= '0;
                ln  <= '0;
            end else if (line_end) begin
                col <= '0;
                ln  <= (ln == LW'(F - 1)) ? '0 : ln + LW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end
endmodule

// File: rtl/ov7670_stream_gen.sv
// rtl/ov7670_stream_gen.sv - frame buffer to OV7670 pixel stream; OV7670_STREAM_TESTPAT_EN adds tp_sel pattern
module ov7670_stream_gen
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_BLANK     = H_BLANK_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int VSYNC_LINES = VSYNC_LINES_DEF,
    parameter int V_BACK      = V_BACK_DEF,
    parameter int V_FRONT     = V_FRONT_DEF,
    parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEF
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              en,
`ifdef OV7670_STREAM_TESTPAT_EN
    input  logic              tp_sel,
`endif
    output logic              fb_rd,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [7:0]        fb_data,
    output logic              vsync,
    output logic              href,
    output logic [7:0]        dout,
    output logic              frame_done
);
    logic raw_vsync, raw_href, raw_rd, raw_fill, raw_start, raw_end;
    logic s1_vsync, s1_href, s1_fill, s1_done, s1_rd;
    logic s2_vsync, s2_href, s2_fill, s2_done;
    logic rd_allow;
    logic [7:0] pix_byte;

`ifdef OV7670_STREAM_TESTPAT_EN
    logic [7:0] raw_pat, s1_pat, s2_pat;
    logic       tp_on;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            tp_on  <= 1'b0;
            s1_pat <= '0;
            s2_pat <= '0;
        end else begin
            if (raw_start) tp_on <= tp_sel;
            s1_pat <= raw_pat;
            s2_pat <= s1_pat;
        end
    end

    assign rd_allow = !tp_on;
    assign pix_byte = tp_on ? s2_pat : fb_data;
`else
    assign rd_allow = 1'b1;
    assign pix_byte = fb_data;
`endif

    ov7670_timing_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .H_BLANK     (H_BLANK),
        .V_ACTIVE    (V_ACTIVE),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) u_timing (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .en          (en),
        .raw_vsync   (raw_vsync),
        .raw_href    (raw_href),
        .raw_rd      (raw_rd),
        .raw_fill    (raw_fill),
        .frame_start (raw_start),
`ifdef OV7670_STREAM_TESTPAT_EN
        .pat         (raw_pat),
`endif
        .frame_end   (raw_end)
    );

    // Stage 1 issues the read, stage 2 meets fb_data, the output register lands the byte.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            {s1_vsync, s1_href, s1_fill, s1_done, s1_rd} <= '0;
            {s2_vsync, s2_href, s2_fill, s2_done}        <= '0;
            fb_rd      <= 1'b0;
            fb_addr    <= '0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            dout       <= '0;
            frame_done <= 1'b0;
        end else begin
            s1_vsync   <= raw_vsync;
            s1_href    <= raw_href;
            s1_fill    <= raw_fill;
            s1_done    <= raw_end;
            s1_rd      <= raw_rd;
            fb_rd      <= raw_rd && rd_allow;
            s2_vsync   <= s1_vsync;
            s2_href    <= s1_href;
            s2_fill    <= s1_fill;
            s2_done    <= s1_done;
            vsync      <= s2_vsync;
            href       <= s2_href;
            frame_done <= s2_done;
            dout       <= s2_href ? (s2_fill ? FILL_BYTE : pix_byte) : 8'h00;
            // The address walks even when reads are suppressed by the test pattern.
            if (raw_start)
                fb_addr <= '0;
            else if (s1_rd)
                fb_addr <= fb_addr + ADDR_W'(1);
        end
    end
endmodule

// File: tb/tb_ov7670_stream_gen.sv
// tb/tb_ov7670_stream_gen.sv - directed checks of the scaled 4x3 frame against a line/column timing model
module tb_ov7670_stream_gen;
    localparam logic [7:0] FILL = 8'hEE;
    localparam int FRAME = 72;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        tp_sel = 1'b0;
    logic        fb_rd;
    logic [18:0] fb_addr;
    logic [7:0]  fb_data = 8'h00;
    logic        vsync, href, frame_done;
    logic [7:0]  dout;
    int total = 0;
    int bad = 0;
    int rd_cnt = 0;

    ov7670_stream_gen #(
        .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1), .FILL_BYTE(FILL)
    ) dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .en         (en),
`ifdef OV7670_STREAM_TESTPAT_EN
        .tp_sel     (tp_sel),
`endif
        .fb_rd      (fb_rd),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .vsync      (vsync),
        .href       (href),
        .dout       (dout),
        .frame_done (frame_done)
    );

    always #5 pclk = ~pclk;

    // Frame buffer whose content at each address is the low address byte.
    always @(posedge pclk) if (fb_rd) fb_data <= fb_addr[7:0];

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {vsync, href, fb_rd, frame_done, dout, fb_addr[15:0]}, 32'h0);
    endtask

    // Output index i of a frame: line i/12, column i%12; reads lead their byte by 2 cycles.
    task automatic check_cycle(input int i, input bit tp);
        int ln, c, j, jl, jc, x, y, ed;
        bit eh, er;
        ln = i / 12; c = i % 12;
        j = i + 2; jl = j / 12; jc = j % 12;
        eh = (ln >= 2) && (ln <= 4) && (c < 8);
        x = c / 2; y = ln - 2;
        ed = !eh ? 0 : (c % 2 == 1) ? int'(FILL) : (tp ? ((x ^ y) & 255) : y * 4 + x);
        er = (j < FRAME) && (jl >= 2) && (jl <= 4) && (jc < 8) && (jc % 2 == 0);
        chk($sformatf("vsync[%0d]", i), 32'(vsync), 32'(ln == 0));
        chk($sformatf("href[%0d]", i), 32'(href), 32'(eh));
        chk($sformatf("dout[%0d]", i), 32'(dout), 32'(ed));
        chk($sformatf("frame_done[%0d]", i), 32'(frame_done), 32'(i == FRAME - 1));
        chk($sformatf("fb_rd[%0d]", i), 32'(fb_rd), 32'(er && !tp));
        if (er) chk($sformatf("fb_addr[%0d]", i), 32'(fb_addr), 32'((jl - 2) * 4 + jc / 2));
        if (i == 0) chk("fb_addr_at_vsync", 32'(fb_addr), 32'h0);
        if (fb_rd) rd_cnt++;
    endtask

    task automatic wait_vsync(input string tag);
        int n;
        n = 0;
        while (vsync !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk(tag, 32'(n), 32'd4);
    endtask

    task automatic run_frame(input int drop_at, input bit tp);
        rd_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            check_cycle(i, tp);
            if (i == drop_at) en = 1'b0;
            step();
        end
        chk("reads_per_frame", 32'(rd_cnt), tp ? 32'd0 : 32'd12);
    endtask

    initial begin
        step();
        chk_zero("in_reset");
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            chk_zero("idle_en0");
        end

        en = 1'b1;
        wait_vsync("start_latency");
        run_frame(-1, 1'b0);
        run_frame(40, 1'b0);
        for (int k = 0; k < 40; k++) begin
            chk("idle_after_drop", {29'h0, vsync, href, fb_rd}, 32'h0);
            step();
        end

        en = 1'b1;
        wait_vsync("restart_latency");
        for (int i = 0; i < 39; i++) begin
            check_cycle(i, 1'b0);
            step();
        end
        chk("mid_active_href", 32'(href), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        for (int k = 0; k < 3; k++) begin
            step();
            chk_zero("held_reset");
        end
        rst_n = 1'b1;
        wait_vsync("post_reset_latency");
        run_frame(10, 1'b0);

`ifdef OV7670_STREAM_TESTPAT_EN
        tp_sel = 1'b1;
        en = 1'b1;
        wait_vsync("tp_latency");
        run_frame(10, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
